ticket_pulse_checker: RTL and testbench

//  Receive end of the ticket-dispense pulse interface: watches the four one-hot dispense lines
//  (one line per ticket type, one high pulse per ticket) and counts pulses per transaction.

---
 rtl/ticket_pkg.sv | 30 +++
 rtl/tkt_edge_detect.sv | 53 +++++
 rtl/ticket_pulse_checker.sv | 161 ++++++++++++++++
 tb/tb_ticket_pulse_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ticket_pkg.sv
// ticket_pkg: shared types and constants for the ticket dispense pulse checker.
//   ticket_type_t : 2-bit ticket line index (0 -> tk_in_i[0])
//   err_code_t    : result code reported when a transaction closes
//   chk_state_t   : checker FSM state, also exported for debug
//   multi_hot()   : true when more than one bit of a line vector is set
package ticket_pkg;

  localparam int NUM_TICKET_TYPES = 4;

  typedef logic [1:0] ticket_type_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_COUNT = 2'b01,
    ERR_STRAY = 2'b10,
    ERR_SIMUL = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } chk_state_t;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [NUM_TICKET_TYPES-1:0] v);
    return (v & (v - NUM_TICKET_TYPES'(1))) != '0;
  endfunction

endpackage

// File: rtl/tkt_edge_detect.sv
// tkt_edge_detect: rising-edge detector for the four dispense lines.
//   clk, rst : clock and asynchronous active-high reset
//   tk_i     : raw dispense lines
//   rise_o   : registered one-cycle rise flags, one per line
// Build option TKT_INPUT_SYNC_EN: adds a 2-flop synchronizer per line in
// front of the detector when the dispenser runs in another clock domain
// (rise latency grows from 1 to 3 cycles).
module tkt_edge_detect
  import ticket_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_TICKET_TYPES-1:0] tk_i,
  output logic [NUM_TICKET_TYPES-1:0] rise_o
);

  logic [NUM_TICKET_TYPES-1:0] tk_s;
  logic [NUM_TICKET_TYPES-1:0] prev_q;
  logic [NUM_TICKET_TYPES-1:0] rise_q;

`ifdef TKT_INPUT_SYNC_EN
  logic [NUM_TICKET_TYPES-1:0] sync1_q;
  logic [NUM_TICKET_TYPES-1:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= tk_i;
      sync2_q <= sync1_q;
    end
  end

  assign tk_s = sync2_q;
`else
  assign tk_s = tk_i;
`endif

  // A line held high produces a single rise: prev_q tracks the last level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      prev_q <= tk_s;
      rise_q <= tk_s & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/ticket_pulse_checker.sv
// ticket_pulse_checker: counts dispense pulses per transaction and checks
// them against the type/count armed by the sale controller.
//   clk, rst     : clock and asynchronous active-high reset
//   arm_i        : one-cycle pulse, latches exp_type_i/exp_count_i (IDLE only)
//   exp_type_i   : expected ticket line 0..3
//   exp_count_i  : expected pulse count 0..3
//   tk_in_i      : one-hot dispense lines
//   busy_o       : transaction open (COLLECT)
//   done_o       : one-cycle pulse when a transaction closes
//   match_o      : pass flag, valid from done_o, held until next arm
//   err_code_o   : 00 ok, 01 count, 10 stray line, 11 simultaneous lines
//   tally_o      : saturating pulse count on the expected line
//   state_o      : FSM state for debug
// Build option TKT_INPUT_SYNC_EN: see tkt_edge_detect.
// Handshake: arm_i is a plain strobe, honoured only while busy_o=0 and
// done_o=0; results are qualified by done_o and stay stable until next arm.
module ticket_pulse_checker
  import ticket_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arm_i,
  input  logic [1:0]                  exp_type_i,
  input  logic [1:0]                  exp_count_i,
  input  logic [NUM_TICKET_TYPES-1:0] tk_in_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        match_o,
  output err_code_t                   err_code_o,
  output logic [CNT_W-1:0]            tally_o,
  output chk_state_t                  state_o
);

  localparam int TMR_W = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_TIMEOUT - 1);

  logic [NUM_TICKET_TYPES-1:0] rise;
  logic [NUM_TICKET_TYPES-1:0] rise_eff;
  logic [NUM_TICKET_TYPES-1:0] exp_mask;
  logic                        any_rise;
  logic                        hit;
  logic                        stray_hit;
  logic [CNT_W-1:0]            tally_d;
  err_code_t                   err_d;

  chk_state_t        state_q;
  ticket_type_t      exp_type_q;
  logic [1:0]        exp_count_q;
  logic [CNT_W-1:0]  tally_q;
  logic [TMR_W-1:0]  timer_q;
  logic              skip_q;
  logic              stray_q;
  logic              simul_q;
  logic              busy_q;
  logic              done_q;
  logic              match_q;
  err_code_t         err_q;

  tkt_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .tk_i   (tk_in_i),
    .rise_o (rise)
  );

  // skip_q marks the first COLLECT cycle: its rise flags were registered at
  // the arm edge and belong to whatever happened before the transaction.
  always_comb begin
    rise_eff  = skip_q ? '0 : rise;
    exp_mask  = NUM_TICKET_TYPES'(1) << exp_type_q;
    any_rise  = |rise_eff;
    hit       = |(rise_eff & exp_mask);
    stray_hit = |(rise_eff & ~exp_mask);
    tally_d   = tally_q;
    if (hit && !(&tally_q)) begin
      tally_d = tally_q + CNT_W'(1);
    end
  end

  always_comb begin
    err_d = ERR_NONE;
    if (simul_q) begin
      err_d = ERR_SIMUL;
    end else if (stray_q) begin
      err_d = ERR_STRAY;
    end else if (tally_q != CNT_W'(exp_count_q)) begin
      err_d = ERR_COUNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      exp_type_q  <= '0;
      exp_count_q <= '0;
      tally_q     <= '0;
      timer_q     <= '0;
      skip_q      <= 1'b0;
      stray_q     <= 1'b0;
      simul_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      skip_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arm_i) begin
            exp_type_q  <= exp_type_i;
            exp_count_q <= exp_count_i;
            tally_q     <= '0;
            timer_q     <= '0;
            stray_q     <= 1'b0;
            simul_q     <= 1'b0;
            match_q     <= 1'b0;
            err_q       <= ERR_NONE;
            skip_q      <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (any_rise) begin
            timer_q <= '0;
            tally_q <= tally_d;
            if (stray_hit) stray_q <= 1'b1;
            if (multi_hot(rise_eff)) simul_q <= 1'b1;
          end else if (timer_q == TMR_LAST) begin
            // Flags are stable here: this cycle carries no rise.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= err_d;
            match_q <= (err_d == ERR_NONE);
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign match_o    = match_q;
  assign err_code_o = err_q;
  assign tally_o    = tally_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_ticket_pulse_checker.sv
// tb_ticket_pulse_checker: directed bench for ticket_pulse_checker
// (default build, CNT_W=4, IDLE_TIMEOUT=8).
module tb_ticket_pulse_checker;
  import ticket_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic [1:0] exp_type;
  logic [1:0] exp_count;
  logic [3:0] tk;
  logic       busy;
  logic       done;
  logic       match;
  err_code_t  err;
  logic [3:0] tally;
  chk_state_t state;

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  logic seen_done;

  ticket_pulse_checker #(.CNT_W(4), .IDLE_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .arm_i       (arm),
    .exp_type_i  (exp_type),
    .exp_count_i (exp_count),
    .tk_in_i     (tk),
    .busy_o      (busy),
    .done_o      (done),
    .match_o     (match),
    .err_code_o  (err),
    .tally_o     (tally),
    .state_o     (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_result(input string pfx, input logic [3:0] e_tally,
                              input logic e_match, input logic [1:0] e_err);
    check({pfx, "_tally"}, 32'(tally), 32'(e_tally));
    check({pfx, "_match"}, 32'(match), 32'(e_match));
    check({pfx, "_err"},   32'(err),   32'(e_err));
    check({pfx, "_busy"},  32'(busy),  32'd0);
  endtask

  // drivers (all inputs change on the falling edge)
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm(input logic [1:0] t, input logic [1:0] c);
    exp_type  = t;
    exp_count = c;
    arm       = 1'b1;
    @(negedge clk);
    arm       = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] mask, input int hi);
    tk = mask;
    repeat (hi) @(negedge clk);
    tk = 4'b0000;
    @(negedge clk);
  endtask

  // Bounded wait; leaves wait_n = negedges elapsed until done was seen.
  task automatic wait_done(input string pfx);
    wait_n = 0;
    while (done !== 1'b1 && wait_n < 60) begin
      @(negedge clk);
      wait_n++;
    end
    check({pfx, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; exp_type = 2'd0; exp_count = 2'd0; tk = 4'b0000;
    cyc(3);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_tally", 32'(tally), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    cyc(2);

    // 1: two good pulses on line 1
    do_arm(2'd1, 2'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_state", 32'(state), 32'd1);
    pulse(4'b0010, 1);
    pulse(4'b0010, 1);
    wait_done("t1");
    check_result("t1", 4'd2, 1'b1, 2'b00);
    @(negedge clk);
    check("t1_done_drop", 32'(done), 32'd0);
    check("t1_match_hold", 32'(match), 32'd1);
    check("t1_state_idle", 32'(state), 32'd0);
    cyc(2);

    // 2: short count on line 3; arm in the DONE cycle is ignored
    do_arm(2'd3, 2'd3);
    pulse(4'b1000, 1);
    pulse(4'b1000, 1);
    wait_done("t2");
    check_result("t2", 4'd2, 1'b0, 2'b01);
    exp_type = 2'd0; exp_count = 2'd0; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("t2_arm_in_done_busy", 32'(busy), 32'd0);
    check("t2_arm_in_done_state", 32'(state), 32'd0);
    check("t2_err_hold", 32'(err), 32'd1);
    cyc(2);

    // 3: stray pulse on line 2
    do_arm(2'd0, 2'd1);
    pulse(4'b0001, 1);
    pulse(4'b0100, 1);
    wait_done("t3");
    check_result("t3", 4'd1, 1'b0, 2'b10);
    cyc(2);

    // 4: simultaneous lines beat stray
    do_arm(2'd2, 2'd1);
    pulse(4'b0110, 1);
    wait_done("t4");
    check_result("t4", 4'd1, 1'b0, 2'b11);
    cyc(2);

    // 5: zero expected, no pulses: done exactly IDLE_TIMEOUT cycles after entry
    do_arm(2'd0, 2'd0);
    wait_done("t5");
    check("t5_latency", 32'(wait_n), 32'd8);
    check_result("t5", 4'd0, 1'b1, 2'b00);
    cyc(2);

    // saturation: 17 pulses on the expected line stop at 15
    do_arm(2'd0, 2'd3);
    for (int i = 0; i < 17; i++) pulse(4'b0001, 1);
    wait_done("sat");
    check_result("sat", 4'd15, 1'b0, 2'b01);
    cyc(2);

    // 6: reset mid-transaction
    do_arm(2'd2, 2'd1);
    pulse(4'b0100, 1);
    cyc(1);
    check("t6_pre_tally", 32'(tally), 32'd1);
    check("t6_pre_busy",  32'(busy),  32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy",  32'(busy),  32'd0);
    check("t6_rst_tally", 32'(tally), 32'd0);
    check("t6_rst_state", 32'(state), 32'd0);
    check("t6_rst_done",  32'(done),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    check("t6_no_done", 32'(seen_done), 32'd0);

    // 6b: arm during COLLECT ignored, level held 5 cycles counts once
    do_arm(2'd1, 2'd1);
    exp_type = 2'd3; exp_count = 2'd0; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    pulse(4'b0010, 5);
    wait_done("t6b");
    check_result("t6b", 4'd1, 1'b1, 2'b00);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
